// File: rtl/dp_ram_arb.sv
// Dual-client arbiter in front of a single-port-per-direction RAM.
// The write and read ports each have their own 1-bit round-robin pointer.
// Read data comes back with a fixed latency of one cycle. A read and a write to
// the same address in the same cycle can optionally forward the write data.
module dp_ram_arb #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,

  // Write clients
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] w_data0,
  input  logic [DATA_W-1:0] w_data1,
  output logic [1:0]        wr_gnt,

  // Read clients
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,

  // RAM side
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_r_data
);

  // Round-robin pointers: index of the client that wins a tie
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;

  // Read response pipeline
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;

  // Same-address forwarding state
  logic              byp_q,      byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  logic hazard;
  logic use_byp;

  // Write grant: combinational from request and pointer, forced idle in reset
  always_comb begin
    wr_gnt = 2'b00;
    if (!rst) begin
      unique case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = wr_ptr_q ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
    end
  end

  // Read grant: same policy with the read pointer
  always_comb begin
    rd_gnt = 2'b00;
    if (!rst) begin
      unique case (rd_req)
        2'b01:   rd_gnt = 2'b01;
        2'b10:   rd_gnt = 2'b10;
        2'b11:   rd_gnt = rd_ptr_q ? 2'b10 : 2'b01;
        default: rd_gnt = 2'b00;
      endcase
    end
  end

  // Pointers move to the client that lost; an idle cycle leaves them alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // gnt[0] set means client 0 won, so client 1 gets priority next
    if (|wr_gnt) wr_ptr_d = wr_gnt[0];
    if (|rd_gnt) rd_ptr_d = rd_gnt[0];
  end

  // RAM write side: mux from the granted client, zero when idle
  always_comb begin
    ram_wr_en   = |wr_gnt;
    ram_wr_addr = '0;
    ram_w_data  = '0;
    if (wr_gnt[0]) begin
      ram_wr_addr = wr_addr0;
      ram_w_data  = w_data0;
    end else if (wr_gnt[1]) begin
      ram_wr_addr = wr_addr1;
      ram_w_data  = w_data1;
    end
  end

  // RAM read side: mux from the granted client, zero when idle
  always_comb begin
    ram_rd_en   = |rd_gnt;
    ram_rd_addr = '0;
    if (rd_gnt[0]) begin
      ram_rd_addr = rd_addr0;
    end else if (rd_gnt[1]) begin
      ram_rd_addr = rd_addr1;
    end
  end

  // Same-cycle read and write to one address: remember the write data
  always_comb begin
    hazard     = ram_rd_en & ram_wr_en & (ram_rd_addr == ram_wr_addr);
    byp_d      = hazard;
    byp_data_d = hazard ? ram_w_data : byp_data_q;
  end

  // Response strobe follows the grant by one cycle
  always_comb begin
    rd_valid_d = rd_gnt;
  end

  // Response outputs; the strobe is masked during reset so a read granted just
  // before reset never shows up as a response
  always_comb begin
    rd_valid  = rst ? 2'b00 : rd_valid_q;
    use_byp   = (BYPASS != 0) && byp_q;
    rd_data_d = rd_data_q;
    if (|rd_valid) begin
      rd_data_d = use_byp ? byp_data_q : ram_r_data;
    end
    rd_data = rd_data_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_valid_q <= 2'b00;
      rd_data_q  <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

endmodule

// File: doc/dp_ram_arb.md
DP_RAM_ARB -- requirements
Module: dp_ram_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_W  5  RAM address width
  DATA_W  8  RAM data width
  BYPASS  1  1 = forward same-cycle write data on a same-address read; 0 = return old data
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  single clock; all logic on posedge
  rst  in  1  synchronous, active-high reset
  wr_req[1:0]  in  2  per-client write request
  wr_addr0, wr_addr1  in  ADDR_W  client write address
  w_data0, w_data1  in  DATA_W  client write data
  wr_gnt[1:0]  out  2  write grant, one-hot or zero
  rd_req[1:0]  in  2  per-client read request
  rd_addr0, rd_addr1  in  ADDR_W  client read address
  rd_gnt[1:0]  out  2  read grant, one-hot or zero
  rd_valid[1:0]  out  2  read response strobe, per client
  rd_data  out  DATA_W  read response data, shared by both clients
  ram_wr_en  out  1  to RAM write enable
  ram_wr_addr  out  ADDR_W  to RAM write address
  ram_w_data  out  DATA_W  to RAM write data
  ram_rd_en  out  1  to RAM read enable
  ram_rd_addr  out  ADDR_W  to RAM read address
  ram_r_data  in  DATA_W  from RAM; valid 1 cycle after ram_rd_en
REQ-003 Clock and reset are fixed as one clock, clk, and a synchronous, active-high reset, rst.

Function
REQ-004 The write port and the read port shall be arbitrated independently, each by its own 1-bit round-robin pointer (wr_ptr, rd_ptr).
REQ-005 Grant rules per port:
  - Grant is combinational from req and ptr.
  - Both clients requesting: grant client ptr.
  - One client requesting: grant that client.
  - No requests: grant 0.
REQ-006 After any granted cycle, ptr shall be set to the non-granted client (ptr <= ~granted index); with no grant, ptr shall hold.
REQ-007 Requesters shall hold req, addr and data until granted; a transfer completes in the cycle req and gnt are both high.
REQ-008 ram_wr_en shall equal |wr_gnt, and ram_wr_addr/ram_w_data shall be muxed from the granted client; with no grant they shall be 0.
REQ-009 ram_rd_en shall equal |rd_gnt, and ram_rd_addr shall be muxed from the granted client; with no grant it shall be 0.
REQ-010 A read granted in cycle N shall return rd_valid[c]=1 for exactly one cycle at N+1, with rd_data for that read; this gives a fixed latency of 1 and allows back-to-back reads every cycle.
REQ-011 Same-address hazard: in cycle N, ram_rd_en & ram_wr_en & (ram_rd_addr==ram_wr_addr) shall register a bypass flag and the write data.
  - BYPASS=1: rd_data at N+1 = registered write data.
  - BYPASS=0: rd_data at N+1 = ram_r_data (old data).
REQ-012 With no hazard, rd_data shall equal ram_r_data while any rd_valid is high; with rd_valid=0, rd_data shall hold its last value.
REQ-013 wr_gnt, rd_gnt and rd_valid shall never have more than one bit set.

Reset
REQ-014 While rst=1: wr_gnt=0, rd_gnt=0, ram_wr_en=0, ram_rd_en=0, and all RAM-side address/data outputs = 0, irrespective of requests.
REQ-015 At the first clk edge with rst=1: wr_ptr=0, rd_ptr=0, rd_valid=0, rd_data=0, bypass flag=0.
REQ-016 A read granted in the cycle before rst asserts shall be squashed: no rd_valid after reset.
REQ-017 Arbitration shall resume in the first cycle after rst deasserts, with client 0 holding priority.

Verification
REQ-018 The bench shall cover these directed scenarios:
  - Reset, then wr_req=2'b11 held for 4 cycles -> wr_gnt sequence 01,10,01,10.
  - Client1 alone writes addr 5 = 0xA5; later client0 reads addr 5 -> rd_gnt=01, next cycle rd_valid=01, rd_data=0xA5.
  - mem[3]=0x11, then in one cycle write 3=0x22 and read 3 with BYPASS=1 -> rd_data=0x22; with BYPASS=0 -> rd_data=0x11; the following read of 3 returns 0x22 in both cases.
  - rd_req=2'b11 held for 4 cycles at addrs 1/2 -> rd_valid alternates 01,10,... one cycle after each grant, data matching the address.
  - Read granted, rst pulsed on the next edge -> rd_valid stays 0; rd_data=0, pointers=0.
  - Random req traffic for 10k cycles -> grants one-hot, no client waits more than 1 cycle while the other holds req, scoreboard matches.
